port_io_scheduler: RTL and testbench
====================================

// Module: port_io_scheduler
// PURPOSE
//  Sequences the CPU's memory-mapped I/O ports onto one shared peripheral link.
//  - Queues CPU port-write notifications per port.
//  - Round-robin grants one port at a time.
//  - Streams that port's two 16-bit words out over a valid/ready bus.
//  - Stages inbound peripheral words into the CPU's port_d_in array and tracks read freshness.
//  Sits between cpu (port_d_out/port_d_in/port_inform_*) and the external I/O fabric.
// PARAMETERS
//  PORT_COUNT  4   number of CPU I/O ports; each port owns 2 words (indices 2p, 2p+1)
//  DATA_W      16  port word width
// PORTS
//  clk                in   1                  system clock, rising edge
//  rst_n              in   1                  asynchronous active-low reset
//  port_inform_write  in   [PORT_COUNT]       1-cycle pulse: CPU has written port p's words
//  port_inform_read   in   [PORT_COUNT]       1-cycle pulse: CPU has read port p's words
//  port_d_out         in   DATA_W x 2*PORT_COUNT  CPU output words
//  port_d_in          out  DATA_W x 2*PORT_COUNT  staged input words to CPU
//  port_fresh         out  [PORT_COUNT]       port p received a full update since last CPU read
//  bus_valid          out  1                  outbound word valid
//  bus_ready          in   1                  peripheral accepts outbound word
//  bus_port           out  $clog2(PORT_COUNT) port index of outbound word
//  bus_word           out  1                  word index within port (0, then 1)
//  bus_last           out  1                  high with word 1
//  bus_data           out  DATA_W             outbound word
//  in_valid           in   1                  inbound word valid (in_ready tied 1, always accepted)
//  in_port            in   $clog2(PORT_COUNT) inbound port index
//  in_word            in   1                  inbound word index
//  in_data            in   DATA_W             inbound word
//  busy               out  1                  FSM not IDLE or any port pending
// BEHAVIOUR
//  Reset (async, rst_n=0): all of the following clear to 0:
//   - pending, port_fresh, port_d_in, shadow regs, rr_ptr
//   - bus_valid, bus_port, bus_word, bus_last, bus_data
//   - state = IDLE
//   Reset mid-transfer drops the word in flight and all queued requests.
//  pending[p]: set the cycle after port_inform_write[p].
//   - Cleared when p is granted.
//   - Set and grant-clear in the same cycle: set wins (port re-queued).
//   - Repeated writes while pending coalesce into one transfer.
//  FSM IDLE -> SEND0 -> SEND1 -> IDLE:
//   - IDLE: if any pending, pick the first pending index searching from rr_ptr upward, wrapping.
//     Latch the index and snapshot port_d_out[2g] and port_d_out[2g+1] into shadow regs.
//     Clear pending[g]; go to SEND0.
//   - SEND0: bus_valid=1, bus_word=0, bus_data=shadow0. Hold all bus outputs stable until
//     bus_ready; then go to SEND1.
//   - SEND1: bus_valid=1, bus_word=1, bus_last=1, bus_data=shadow1. On bus_ready:
//     rr_ptr=(g+1) mod PORT_COUNT; go to IDLE.
//  Latency: inform_write at cycle n -> bus_valid earliest at n+2. Back-to-back ports cost one
//   IDLE cycle between transfers.
//  CPU rewriting a port mid-transfer: does not corrupt the words in flight (shadowed); it only
//   re-pends the port.
//  Inbound: on in_valid, port_d_in[2*in_port+in_word] <= in_data the next cycle.
//   - in_word=1 also sets port_fresh[in_port].
//   - in_port >= PORT_COUNT: word ignored.
//  port_fresh[p]: cleared by port_inform_read[p]; simultaneous set and clear -> set wins.
// STRUCTURE
//  Package eye_io_pkg: io_state_e {IDLE, SEND0, SEND1}, PORT_IDX_W = $clog2(PORT_COUNT),
//   WORDS_PER_PORT = 2.
//  Sub-module rr_arbiter #(N) provides the grant logic:
//   - in:  req[N], ptr
//   - out: gnt_valid, gnt_idx
//   - combinational, first request at or above ptr, wrapping.
//  Top level holds pending/fresh registers, the FSM, shadow regs and input staging.
// TESTING
//  1. Single write: pulse inform_write[2] with d_out[4]=0x1234, d_out[5]=0xABCD, bus_ready=1.
//     -> two beats {port 2, w0, 0x1234} then {port 2, w1, last, 0xABCD}; first beat at n+2.
//  2. Fairness: pulse inform_write[0..3] together, rr_ptr=0, bus_ready=1.
//     -> grant order 0,1,2,3. Then re-pend 0 and 3 -> order 0,3.
//  3. Backpressure: hold bus_ready=0 for 5 cycles in SEND0.
//     -> bus_valid/data/port stable; no advance.
//     Change d_out[port] meanwhile -> the old words are sent, then the port re-sends the new.
//  4. Same-cycle set/clear: inform_write[1] in the same cycle port 1 is granted.
//     -> port 1 transferred twice. Same check on fresh: in_word=1 with inform_read -> fresh stays 1.
//  5. Inbound: in_valid {port 3, w0, 0x55AA} then {port 3, w1, 0x0F0F}.
//     -> d_in[6]=0x55AA, d_in[7]=0x0F0F, fresh[3]=1. inform_read[3] -> fresh[3]=0.
//     in_port=7 with PORT_COUNT=4 -> no change.
//  6. Reset: assert rst_n=0 mid-SEND1.
//     -> bus_valid=0 immediately (async), all pending=0, rr_ptr=0, d_in all 0.

Source files
------------

// File: rtl/port_io_scheduler_pkg.sv
// Shared types and constants for the CPU port I/O scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eye_io_pkg;

  localparam int PORT_COUNT_DEF = 4;
  localparam int DATA_W_DEF     = 16;
  localparam int PORT_IDX_W     = $clog2(PORT_COUNT_DEF);
  localparam int WORDS_PER_PORT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } io_state_e;

endpackage

// File: rtl/port_io_scheduler_if.sv
// Peripheral link bundle: outbound word stream plus inbound word stream.
// Latency: n/a (wires only).
// Backpressure: outbound honours bus_ready; inbound is always accepted.
//   master (scheduler): drives bus_* except bus_ready, receives in_*
//   slave  (fabric)   : drives bus_ready and in_*, receives bus_*
interface port_io_scheduler_if #(
  parameter int PORT_COUNT = eye_io_pkg::PORT_COUNT_DEF,
  parameter int DATA_W     = eye_io_pkg::DATA_W_DEF
);
  localparam int IDX_W = $clog2(PORT_COUNT);

  logic              bus_valid;
  logic              bus_ready;
  logic [IDX_W-1:0]  bus_port;
  logic              bus_word;
  logic              bus_last;
  logic [DATA_W-1:0] bus_data;

  logic              in_valid;
  logic [IDX_W-1:0]  in_port;
  logic              in_word;
  logic [DATA_W-1:0] in_data;

  modport master (
    output bus_valid, bus_port, bus_word, bus_last, bus_data,
    input  bus_ready,
    input  in_valid, in_port, in_word, in_data
  );

  modport slave (
    input  bus_valid, bus_port, bus_word, bus_last, bus_data,
    output bus_ready,
    output in_valid, in_port, in_word, in_data
  );

endinterface

// File: rtl/port_io_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted req at or above ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the grant.
//   req[N] in, ptr in, gnt_valid out, gnt_idx out
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req[cand[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/port_io_scheduler.sv
// Queues CPU port writes, round-robins them onto the peripheral link as two
//   words per port, and stages inbound words into port_d_in with freshness flags.
// Latency: inform_write at cycle n -> bus_valid at n+2; one IDLE cycle between ports.
// Backpressure: outbound beat held stable until bus_ready; inbound never stalls.
//   Ports: clk, rst_n; port_inform_write/read pulses; port_d_out (CPU words in);
//   port_d_in/port_fresh (staged words out); busy; bus (link interface, master side).
module port_io_scheduler
  import eye_io_pkg::*;
#(
  parameter int PORT_COUNT = PORT_COUNT_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_COUNT-1:0] port_inform_write,
  input  logic [PORT_COUNT-1:0] port_inform_read,
  input  logic [DATA_W-1:0]     port_d_out [WORDS_PER_PORT*PORT_COUNT],
  output logic [DATA_W-1:0]     port_d_in  [WORDS_PER_PORT*PORT_COUNT],
  output logic [PORT_COUNT-1:0] port_fresh,
  output logic                  busy,
  port_io_scheduler_if.master   bus
);
  localparam int IDX_W = $clog2(PORT_COUNT);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SEND0 = SEND0;
  localparam logic [1:0] ST_SEND1 = SEND1;

  logic [1:0]            state;
  logic [PORT_COUNT-1:0] pending;
  logic [PORT_COUNT-1:0] gnt_mask;
  logic [PORT_COUNT-1:0] fresh_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      cur_port;
  logic [DATA_W-1:0]     shadow0;
  logic [DATA_W-1:0]     shadow1;
  logic                  gnt_valid;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  grant;
  logic                  in_ok;

  rr_arbiter #(.N(PORT_COUNT)) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant = (state == ST_IDLE) && gnt_valid;

  always_comb begin
    gnt_mask = '0;
    if (grant) begin
      gnt_mask = {{(PORT_COUNT-1){1'b0}}, 1'b1} << gnt_idx;
    end
  end

  // OR-ing the new writes after the grant clear lets a write that lands on
  // the grant cycle re-queue the port instead of being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~gnt_mask) | port_inform_write;
    end
  end

  // Words are snapshotted at grant so CPU rewrites cannot tear a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      cur_port <= '0;
      shadow0  <= '0;
      shadow1  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            cur_port <= gnt_idx;
            shadow0  <= port_d_out[{gnt_idx, 1'b0}];
            shadow1  <= port_d_out[{gnt_idx, 1'b1}];
            state    <= ST_SEND0;
          end
        end
        ST_SEND0: begin
          if (bus.bus_ready) begin
            state <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          if (bus.bus_ready) begin
            rr_ptr <= (cur_port == IDX_W'(PORT_COUNT - 1)) ? '0 : cur_port + IDX_W'(1);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from registered state, so reset drops them at once.
  assign bus.bus_valid = (state != ST_IDLE);
  assign bus.bus_word  = (state == ST_SEND1);
  assign bus.bus_last  = (state == ST_SEND1);
  assign bus.bus_port  = cur_port;
  assign bus.bus_data  = (state == ST_SEND1) ? shadow1 : shadow0;

  assign busy = (state != ST_IDLE) || (|pending);

  // Guard only matters for non-power-of-two port counts.
  assign in_ok = bus.in_valid && (int'(bus.in_port) < PORT_COUNT);

  always_comb begin
    fresh_nxt = port_fresh & ~port_inform_read;
    if (in_ok && bus.in_word) begin
      fresh_nxt[bus.in_port] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_PORT * PORT_COUNT; i++) begin
        port_d_in[i] <= '0;
      end
      port_fresh <= '0;
    end else begin
      if (in_ok) begin
        port_d_in[{bus.in_port, bus.in_word}] <= bus.in_data;
      end
      port_fresh <= fresh_nxt;
    end
  end

endmodule

// File: tb/tb_port_io_scheduler.sv
// Scoreboard bench for port_io_scheduler: stimulus pushes expected outbound
// beats, a negedge monitor pops and compares every accepted beat and checks
// that a stalled beat holds steady.
module tb_port_io_scheduler;
  import eye_io_pkg::*;

  localparam int PC = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    port;
    logic          word;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PC-1:0] inform_write;
  logic [PC-1:0] inform_read;
  logic [DW-1:0] d_out [2*PC];
  logic [DW-1:0] d_in  [2*PC];
  logic [PC-1:0] fresh;
  logic          busy;

  beat_t exp_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  port_io_scheduler_if #(.PORT_COUNT(PC), .DATA_W(DW)) bus_if ();

  port_io_scheduler #(.PORT_COUNT(PC), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .port_inform_write (inform_write),
    .port_inform_read  (inform_read),
    .port_d_out        (d_out),
    .port_d_in         (d_in),
    .port_fresh        (fresh),
    .busy              (busy),
    .bus               (bus_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [1:0] p, input logic w, input logic [DW-1:0] d);
    beat_t b;
    b.port = p;
    b.word = w;
    b.last = w;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic push_xfer(input logic [1:0] p, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    push_beat(p, 1'b0, d0);
    push_beat(p, 1'b1, d1);
  endtask

  task automatic pulse_write(input logic [PC-1:0] m);
    inform_write = m;
    tick();
    inform_write = '0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_idle"}, {31'd0, done}, 32'd1);
    check({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.bus_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_valid"}, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_cleared(input string name);
    logic [DW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 2*PC; i++) acc = acc | d_in[i];
    check({name, "_bus_valid"}, {31'd0, bus_if.bus_valid}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_fresh"}, {28'd0, fresh}, 32'd0);
    check({name, "_d_in"}, {16'd0, acc}, 32'd0);
  endtask

  // Monitor: one negedge per clock, so valid&ready here means one accepted beat.
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {bus_if.bus_port, bus_if.bus_word, bus_if.bus_last, bus_if.bus_data};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_stable", {11'd0, bus_if.bus_valid, cur}, {11'd0, 1'b1, prev_beat});
      end
      if (bus_if.bus_valid && bus_if.bus_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", {12'd0, cur}, {12'd0, e});
        end
        prev_stall = 1'b0;
      end else if (bus_if.bus_valid) begin
        prev_beat  = cur;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    inform_write     = '0;
    inform_read      = '0;
    bus_if.bus_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_port   = '0;
    bus_if.in_word   = 1'b0;
    bus_if.in_data   = '0;
    for (int i = 0; i < 2*PC; i++) d_out[i] = '0;
    tick();
    tick();

    // Reset state
    check_cleared("rst");
    check("rst_bus_data", {16'd0, bus_if.bus_data}, 32'd0);
    check("rst_bus_port_word_last",
          {28'd0, bus_if.bus_port, bus_if.bus_word, bus_if.bus_last}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Single write on port 2, first beat two edges after the pulse
    bus_if.bus_ready = 1'b1;
    d_out[4] = 16'h1234;
    d_out[5] = 16'hABCD;
    push_xfer(2'd2, 16'h1234, 16'hABCD);
    inform_write = 4'b0100;
    tick();
    inform_write = '0;
    check("lat_n1_valid", {31'd0, bus_if.bus_valid}, 32'd0);
    tick();
    check("lat_n2_valid", {31'd0, bus_if.bus_valid}, 32'd1);
    check("lat_n2_port", {30'd0, bus_if.bus_port}, 32'd2);
    wait_idle("single");

    // 2. Fairness from rr_ptr=0, then re-pend 0 and 3
    do_reset();
    for (int i = 0; i < 2*PC; i++) d_out[i] = 16'h2000 + 16'(i);
    push_xfer(2'd0, 16'h2000, 16'h2001);
    push_xfer(2'd1, 16'h2002, 16'h2003);
    push_xfer(2'd2, 16'h2004, 16'h2005);
    push_xfer(2'd3, 16'h2006, 16'h2007);
    pulse_write(4'b1111);
    wait_idle("rr_all");
    push_xfer(2'd0, 16'h2000, 16'h2001);
    push_xfer(2'd3, 16'h2006, 16'h2007);
    pulse_write(4'b1001);
    wait_idle("rr_0_3");

    // 3. Backpressure in SEND0 with a CPU rewrite during the stall
    bus_if.bus_ready = 1'b0;
    d_out[2] = 16'hA1A1;
    d_out[3] = 16'hA2A2;
    push_xfer(2'd1, 16'hA1A1, 16'hA2A2);
    push_xfer(2'd1, 16'hB1B1, 16'hB2B2);
    pulse_write(4'b0010);
    wait_valid("bp");
    d_out[2] = 16'hB1B1;
    d_out[3] = 16'hB2B2;
    pulse_write(4'b0010);
    for (int i = 0; i < 4; i++) begin
      check("bp_word0", {31'd0, bus_if.bus_word}, 32'd0);
      tick();
    end
    check("bp_data_old", {16'd0, bus_if.bus_data}, 32'h0000A1A1);
    bus_if.bus_ready = 1'b1;
    wait_idle("bp");

    // 4. Write landing on the grant cycle re-queues the port
    d_out[2] = 16'h4444;
    d_out[3] = 16'h5555;
    push_xfer(2'd1, 16'h4444, 16'h5555);
    push_xfer(2'd1, 16'h4444, 16'h5555);
    inform_write = 4'b0010;
    tick();
    tick();
    inform_write = '0;
    wait_idle("set_wins");

    // Fresh: set and read in the same cycle keeps fresh set
    bus_if.in_valid = 1'b1;
    bus_if.in_port  = 2'd0;
    bus_if.in_word  = 1'b1;
    bus_if.in_data  = 16'h7777;
    tick();
    bus_if.in_valid = 1'b0;
    check("fresh0_set", {31'd0, fresh[0]}, 32'd1);
    check("d_in1", {16'd0, d_in[1]}, 32'h00007777);
    bus_if.in_valid = 1'b1;
    inform_read     = 4'b0001;
    tick();
    bus_if.in_valid = 1'b0;
    inform_read     = '0;
    check("fresh0_set_wins", {31'd0, fresh[0]}, 32'd1);
    inform_read = 4'b0001;
    tick();
    inform_read = '0;
    check("fresh0_clear", {31'd0, fresh[0]}, 32'd0);

    // 5. Inbound staging on port 3
    bus_if.in_valid = 1'b1;
    bus_if.in_port  = 2'd3;
    bus_if.in_word  = 1'b0;
    bus_if.in_data  = 16'h55AA;
    tick();
    check("d_in6", {16'd0, d_in[6]}, 32'h000055AA);
    check("fresh3_after_w0", {31'd0, fresh[3]}, 32'd0);
    bus_if.in_word = 1'b1;
    bus_if.in_data = 16'h0F0F;
    tick();
    bus_if.in_valid = 1'b0;
    check("d_in7", {16'd0, d_in[7]}, 32'h00000F0F);
    check("fresh3_set", {31'd0, fresh[3]}, 32'd1);
    // Data without in_valid must not land (2-bit port field has no out-of-range index)
    bus_if.in_word = 1'b0;
    bus_if.in_data = 16'hFFFF;
    tick();
    check("d_in6_no_valid", {16'd0, d_in[6]}, 32'h000055AA);
    inform_read = 4'b1000;
    tick();
    inform_read = '0;
    check("fresh3_clear", {31'd0, fresh[3]}, 32'd0);

    // 6. Reset in the middle of SEND1 (rr_ptr is 2 beforehand)
    bus_if.bus_ready = 1'b0;
    d_out[0] = 16'h0A0A;
    d_out[1] = 16'h0B0B;
    d_out[4] = 16'h6060;
    d_out[5] = 16'h6161;
    push_beat(2'd2, 1'b0, 16'h6060);
    pulse_write(4'b0101);
    wait_valid("rst_mid");
    check("rst_mid_port", {30'd0, bus_if.bus_port}, 32'd2);
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    check("rst_mid_in_send1", {30'd0, bus_if.bus_word, bus_if.bus_last}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    // rr_ptr back at 0: ports 1 and 3 pending together must go 1 then 3
    d_out[2] = 16'h1111;
    d_out[3] = 16'h2222;
    d_out[6] = 16'h3333;
    d_out[7] = 16'h4444;
    push_xfer(2'd1, 16'h1111, 16'h2222);
    push_xfer(2'd3, 16'h3333, 16'h4444);
    bus_if.bus_ready = 1'b1;
    pulse_write(4'b1010);
    wait_idle("rst_ptr");

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
